bht_predictor: RTL and testbench

//  Branch history table of 2-bit saturating counters: predicts at fetch (read side) and trains at resolve (write side).

---
 rtl/bp_pkg.sv | 21 ++
 rtl/bht_predictor_two_bits_fsm.sv | 22 ++
 rtl/bht_predictor.sv | 127 ++++++++++++
 tb/tb_bht_predictor.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared encodings and helpers for the branch predictor.
// Counter values, control states and PC-to-index mapping.
package bp_pkg;

  localparam logic [1:0] STRONGLY_NOT = 2'd0;
  localparam logic [1:0] WEAKLY_NOT   = 2'd1;
  localparam logic [1:0] WEAKLY_YES   = 2'd2;
  localparam logic [1:0] STRONGLY_YES = 2'd3;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  // Word index: drop byte offset, keep the low `bits` bits.
  function automatic logic [31:0] pc_to_index(
    input logic [31:0] pc,
    input int unsigned bits
  );
    return (pc >> 2) & ~(32'hFFFF_FFFF << bits);
  endfunction

endpackage

// File: rtl/bht_predictor_two_bits_fsm.sv
// Two-bit saturating counter next-state logic.
// Purely combinational; one step toward the actual outcome.
module TWO_BITS_FSM
  import bp_pkg::*;
(
  input  logic [1:0] cur,
  input  logic       taken,
  output logic [1:0] nxt
);

  // Saturating step up on taken, down on not-taken
  always_comb begin
    nxt = cur;
    unique case (cur)
      STRONGLY_NOT: nxt = taken ? WEAKLY_NOT   : STRONGLY_NOT;
      WEAKLY_NOT:   nxt = taken ? WEAKLY_YES   : STRONGLY_NOT;
      WEAKLY_YES:   nxt = taken ? STRONGLY_YES : WEAKLY_NOT;
      STRONGLY_YES: nxt = taken ? STRONGLY_YES : WEAKLY_YES;
    endcase
  end

endmodule

// File: rtl/bht_predictor.sv
// Branch history table of 2-bit counters.
// Registered prediction, pipelined training, table clear, stats.
module bht_predictor
  import bp_pkg::*;
#(
  parameter int         INDEX_BITS = 6,
  parameter int         PC_WIDTH   = 32,
  parameter logic [1:0] INIT_STATE = 2'd1,
  parameter int         STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pred_req,
  input  logic [PC_WIDTH-1:0]   pred_pc,
  output logic                  pred_valid,
  output logic                  pred_taken,
  output logic [1:0]            pred_state,
  input  logic                  upd_valid,
  input  logic [PC_WIDTH-1:0]   upd_pc,
  input  logic                  upd_taken,
  input  logic                  upd_mispredict,
  input  logic                  clear_req,
  output logic                  busy,
  output logic [STAT_WIDTH-1:0] upd_count,
  output logic [STAT_WIDTH-1:0] mispred_count
);

  localparam int DEPTH = 2 ** INDEX_BITS;

  logic [1:0]            bht [DEPTH];
  logic [0:0]            state;
  logic [INDEX_BITS-1:0] clr_ptr;
  logic [INDEX_BITS-1:0] pred_idx;
  logic [INDEX_BITS-1:0] upd_idx;
  logic [INDEX_BITS-1:0] u1_idx;
  logic                  u1_taken;
  logic                  u1_valid;
  logic [1:0]            nxt;
  logic                  idle;
  logic                  accept;

  assign pred_idx = INDEX_BITS'(pc_to_index(32'(pred_pc), INDEX_BITS));
  assign upd_idx  = INDEX_BITS'(pc_to_index(32'(upd_pc), INDEX_BITS));

  assign idle       = (state == ST_IDLE);
  assign busy       = (state == ST_CLEAR);
  assign accept     = idle && upd_valid && !clear_req;
  assign pred_taken = pred_state[1];

  TWO_BITS_FSM u_fsm (
    .cur   (bht[u1_idx]),
    .taken (u1_taken),
    .nxt   (nxt)
  );

  // Control state and clear pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      clr_ptr <= '0;
    end else if (busy) begin
      clr_ptr <= clr_ptr + INDEX_BITS'(1);
      if (clr_ptr == INDEX_BITS'(DEPTH - 1)) state <= ST_IDLE;
    end else if (clear_req) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
    end
  end

  // Capture stage of the update pipeline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      u1_valid <= 1'b0;
      u1_idx   <= '0;
      u1_taken <= 1'b0;
    end else begin
      u1_valid <= accept;
      if (accept) begin
        u1_idx   <= upd_idx;
        u1_taken <= upd_taken;
      end
    end
  end

  // Table writes: clear sweep or committed update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) bht[i] <= INIT_STATE;
    end else if (busy) begin
      bht[clr_ptr] <= INIT_STATE;
    end else if (u1_valid) begin
      bht[u1_idx] <= nxt;
    end
  end

  // Registered prediction with same-edge write bypass
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_valid <= 1'b0;
      pred_state <= INIT_STATE;
    end else begin
      pred_valid <= pred_req;
      if (pred_req) begin
        if (busy)
          pred_state <= INIT_STATE;
        else if (u1_valid && u1_idx == pred_idx)
          pred_state <= nxt;
        else
          pred_state <= bht[pred_idx];
      end
    end
  end

  // Saturating statistics on accepted updates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_count     <= '0;
      mispred_count <= '0;
    end else if (accept) begin
      if (upd_count != '1)
        upd_count <= upd_count + STAT_WIDTH'(1);
      if (upd_mispredict && mispred_count != '1)
        mispred_count <= mispred_count + STAT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_bht_predictor.sv
// Directed testbench for bht_predictor.
// Scenario tasks with inline checks against hand-computed values.
module tb_bht_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        pred_req;
  logic [31:0] pred_pc;
  logic        pred_valid;
  logic        pred_taken;
  logic [1:0]  pred_state;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        upd_mispredict;
  logic        clear_req;
  logic        busy;
  logic [15:0] upd_count;
  logic [15:0] mispred_count;

  int checks = 0;
  int errors = 0;

  bht_predictor dut (
    .clk            (clk),
    .rst            (rst),
    .pred_req       (pred_req),
    .pred_pc        (pred_pc),
    .pred_valid     (pred_valid),
    .pred_taken     (pred_taken),
    .pred_state     (pred_state),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_mispredict (upd_mispredict),
    .clear_req      (clear_req),
    .busy           (busy),
    .upd_count      (upd_count),
    .mispred_count  (mispred_count)
  );

  always #5 clk = ~clk;

  task automatic upd(input logic [31:0] pc, input logic t, input logic mp);
    @(negedge clk);
    upd_valid = 1'b1;
    upd_pc = pc;
    upd_taken = t;
    upd_mispredict = mp;
    @(negedge clk);
    upd_valid = 1'b0;
    upd_mispredict = 1'b0;
  endtask

  task automatic pred(input logic [31:0] pc, output logic [1:0] st,
                      output logic v);
    @(negedge clk);
    pred_req = 1'b1;
    pred_pc = pc;
    @(posedge clk);
    #1;
    st = pred_state;
    v = pred_valid;
    @(negedge clk);
    pred_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (pred_valid !== 1'b0) begin
      errors++; $display("FAIL reset_pred_valid got %0b want 0", pred_valid);
    end
    checks++;
    if (pred_state !== 2'd1) begin
      errors++; $display("FAIL reset_pred_state got %0d want 1", pred_state);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got %0b want 0", busy);
    end
    checks++;
    if (upd_count !== 16'd0 || mispred_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_stats got %0d/%0d want 0/0", upd_count, mispred_count);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_first_pred();
    logic [1:0] st;
    logic v;
    pred(32'h40, st, v);
    checks++;
    if (v !== 1'b1 || st !== 2'd1 || pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL first_pred got v=%0b st=%0d tk=%0b want 1/1/0", v, st, pred_taken);
    end
    @(posedge clk);
    #1;
    checks++;
    if (pred_valid !== 1'b0) begin
      errors++; $display("FAIL no_req_valid got %0b want 0", pred_valid);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_st [7];
    logic [1:0] st;
    logic v;
    exp_st = '{2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0, 2'd0};
    for (int i = 0; i < 7; i++) begin
      upd(32'h40, (i < 3), 1'b0);
      pred(32'h40, st, v);
      checks++;
      if (st !== exp_st[i] || pred_taken !== exp_st[i][1]) begin
        errors++;
        $display("FAIL saturate_%0d got %0d want %0d", i, st, exp_st[i]);
      end
    end
    checks++;
    if (upd_count !== 16'd7 || mispred_count !== 16'd0) begin
      errors++;
      $display("FAIL sat_stats got %0d/%0d want 7/0", upd_count, mispred_count);
    end
  endtask

  task automatic test_back_to_back();
    upd(32'h40, 1'b1, 1'b0);
    @(negedge clk);
    upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1;
    @(negedge clk);
    upd_valid = 1'b0;
    pred_req = 1'b1; pred_pc = 32'h40;
    @(posedge clk);
    #1;
    checks++;
    if (pred_state !== 2'd2) begin
      errors++; $display("FAIL bypass got %0d want 2", pred_state);
    end
    @(negedge clk);
    pred_req = 1'b0;
    upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b0;
    @(negedge clk);
    upd_pc = 32'h40; upd_taken = 1'b0;
    @(negedge clk);
    upd_valid = 1'b0;
    pred_req = 1'b1; pred_pc = 32'h40;
    @(posedge clk);
    #1;
    checks++;
    if (pred_state !== 2'd0) begin
      errors++; $display("FAIL back_to_back got %0d want 0", pred_state);
    end
    @(negedge clk);
    pred_req = 1'b0;
  endtask

  task automatic test_alias();
    logic [1:0] st;
    logic v;
    upd(32'h40, 1'b1, 1'b0);
    pred(32'h140, st, v);
    checks++;
    if (st !== 2'd1) begin
      errors++; $display("FAIL alias_140 got %0d want 1", st);
    end
    upd(32'h41, 1'b1, 1'b1);
    pred(32'h40, st, v);
    checks++;
    if (st !== 2'd2) begin
      errors++; $display("FAIL alias_41 got %0d want 2", st);
    end
    pred(32'h44, st, v);
    checks++;
    if (st !== 2'd1) begin
      errors++; $display("FAIL neighbour got %0d want 1", st);
    end
    checks++;
    if (upd_count !== 16'd13 || mispred_count !== 16'd1) begin
      errors++;
      $display("FAIL alias_stats got %0d/%0d want 13/1", upd_count, mispred_count);
    end
  endtask

  task automatic test_clear();
    logic [1:0] st;
    logic v;
    int cnt;
    for (int i = 0; i < 3; i++) begin
      upd(32'h0, 1'b1, 1'b0);
      upd(32'hFC, 1'b1, 1'b0);
    end
    pred(32'hFC, st, v);
    checks++;
    if (st !== 2'd3) begin
      errors++; $display("FAIL train_63 got %0d want 3", st);
    end
    @(negedge clk);
    clear_req = 1'b1;
    upd_valid = 1'b1; upd_pc = 32'h80; upd_taken = 1'b1; upd_mispredict = 1'b1;
    @(posedge clk);
    #1;
    cnt = busy ? 1 : 0;
    @(negedge clk);
    clear_req = 1'b0;
    upd_pc = 32'h40;
    pred_req = 1'b1; pred_pc = 32'hFC;
    while (busy && cnt < 200) begin
      @(posedge clk);
      #1;
      if (cnt == 1) begin
        checks++;
        if (pred_valid !== 1'b1 || pred_state !== 2'd1 || pred_taken !== 1'b0) begin
          errors++;
          $display("FAIL busy_pred got v=%0b st=%0d want 1/1", pred_valid, pred_state);
        end
      end
      if (busy) cnt++;
    end
    @(negedge clk);
    upd_valid = 1'b0; upd_mispredict = 1'b0; pred_req = 1'b0;
    checks++;
    if (cnt !== 64) begin
      errors++; $display("FAIL busy_cycles got %0d want 64", cnt);
    end
    checks++;
    if (upd_count !== 16'd19 || mispred_count !== 16'd1) begin
      errors++;
      $display("FAIL clear_stats got %0d/%0d want 19/1", upd_count, mispred_count);
    end
    for (int i = 0; i < 64; i++) begin
      pred(32'(i * 4), st, v);
      checks++;
      if (st !== 2'd1) begin
        errors++; $display("FAIL cleared_%0d got %0d want 1", i, st);
      end
    end
  endtask

  task automatic test_stats_saturate();
    @(negedge clk);
    upd_valid = 1'b1; upd_pc = 32'h80; upd_taken = 1'b0; upd_mispredict = 1'b1;
    repeat (32'hFFFF + 2) @(posedge clk);
    @(negedge clk);
    upd_valid = 1'b0; upd_mispredict = 1'b0;
    checks++;
    if (upd_count !== 16'hFFFF) begin
      errors++; $display("FAIL upd_sat got %h want ffff", upd_count);
    end
    checks++;
    if (mispred_count !== 16'hFFFF) begin
      errors++; $display("FAIL mp_sat got %h want ffff", mispred_count);
    end
  endtask

  task automatic test_reset_mid_clear();
    logic [1:0] st;
    logic v;
    for (int i = 0; i < 2; i++) upd(32'hFC, 1'b1, 1'b0);
    @(negedge clk);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL mid_clear_busy got %0b want 1", busy);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || upd_count !== 16'd0 || mispred_count !== 16'd0) begin
      errors++;
      $display("FAIL abort got busy=%0b %0d/%0d want 0 0/0", busy, upd_count, mispred_count);
    end
    checks++;
    if (pred_state !== 2'd1 || pred_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_pred got st=%0d v=%0b want 1/0", pred_state, pred_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    pred(32'hFC, st, v);
    checks++;
    if (st !== 2'd1) begin
      errors++; $display("FAIL abort_entry63 got %0d want 1", st);
    end
  endtask

  initial begin
    rst = 1'b1;
    pred_req = 1'b0; pred_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_mispredict = 1'b0;
    clear_req = 1'b0;
    test_reset();
    test_first_pred();
    test_saturation();
    test_back_to_back();
    test_alias();
    test_clear();
    test_stats_saturate();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
